// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    localparam int ADDR_WIDTH_DEFAULT = 1;
    localparam int DATA_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/apb_requester_props.sv
// Requester-side APB protocol properties; bind or instantiate next to apb_requester.
module apb_requester_props #(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 32
) (
    input logic                  PCLK,
    input logic                  PRESET,
    input logic                  PSEL,
    input logic                  PENABLE,
    input logic                  PWRITE,
    input logic                  PREADY,
    input logic [ADDR_WIDTH-1:0] PADDR,
    input logic [DATA_WIDTH-1:0] PWDATA
);

    penable_implies_psel: assert property (
        @(posedge PCLK) disable iff (PRESET) PENABLE |-> PSEL);

    psel_rise_in_setup: assert property (
        @(posedge PCLK) disable iff (PRESET) $rose(PSEL) |-> !PENABLE);

    // Address phase signals may only change once the transfer has completed.
    addr_phase_stable: assert property (
        @(posedge PCLK) disable iff (PRESET)
        (PSEL && !(PENABLE && PREADY)) |=>
            ($stable(PADDR) && $stable(PWRITE) && $stable(PWDATA)));

endmodule

// File: rtl/apb_requester.sv
// APB3 requester: one local command in, one APB transfer out, one response back.
module apb_requester
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_slverr,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    input  logic [DATA_WIDTH-1:0] PRDATA
);

    state_t state;
    state_t state_next;
    logic   accept;

    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = SETUP;
            SETUP:                  state_next = ACCESS;
            ACCESS:  if (PREADY)    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Every output is decoded from the next state so it is registered, not combinational.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state      <= IDLE;
            cmd_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
        end else begin
            state     <= state_next;
            cmd_ready <= (state_next == IDLE);
            PSEL      <= (state_next == SETUP) || (state_next == ACCESS);
            PENABLE   <= (state_next == ACCESS);
            rsp_valid <= (state_next == RESP);
            if (accept) begin
                PWRITE <= cmd_write;
                PADDR  <= cmd_addr;
                PWDATA <= cmd_wdata;
            end
            // Completer status is only meaningful on the completing ACCESS cycle.
            if (state == ACCESS && PREADY) begin
                rsp_slverr <= PSLVERR;
                rsp_rdata  <= PWRITE ? '0 : PRDATA;
            end
        end
    end

endmodule
